// File: rtl/control_contador_regresivo.sv
// Sequencer for the contador_regresivo countdown counter.
// It conditions the start and pause buttons, loads the start value into the
// counter and paces single-cycle decrement strobes from a clock prescaler.
// Counting stops at zero and the counter is never decremented below it.
module control_contador_regresivo #(
  parameter int WIDTH    = 6,
  parameter int TICK_DIV = 50_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pause,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] cnt_val,
  output logic [WIDTH-1:0] cnt_num,
  output logic             cnt_load_n,
  output logic             cnt_dec_n,
  output logic             running,
  output logic             done,
  output logic [2:0]       state
);

  localparam int            PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] TC = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Button conditioning: two-flop synchronizers followed by edge flops
  logic r_start_s1, r_start_s2, r_start_d;
  logic r_pause_s1, r_pause_s2, r_pause_d;
  logic w_start_ev, w_pause_ev;

  // Controller state and registered outputs
  state_t          r_state, w_state;
  logic [PW-1:0]   r_presc, w_presc;
  logic [WIDTH-1:0] r_num, w_num;
  logic            r_load_n, w_load_n;
  logic            r_dec_n, w_dec_n;
  // Set while the final strobe (count 1 -> 0) is being issued
  logic            r_last, w_last;

  // Synchronize the asynchronous buttons and remember the previous level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_start_s1 <= 1'b0;
      r_start_s2 <= 1'b0;
      r_start_d  <= 1'b0;
      r_pause_s1 <= 1'b0;
      r_pause_s2 <= 1'b0;
      r_pause_d  <= 1'b0;
    end else begin
      r_start_s1 <= start;
      r_start_s2 <= r_start_s1;
      r_start_d  <= r_start_s2;
      r_pause_s1 <= pause;
      r_pause_s2 <= r_pause_s1;
      r_pause_d  <= r_pause_s2;
    end
  end

  // One event per press: rising edge of the synchronized level
  assign w_start_ev = r_start_s2 & ~r_start_d;
  assign w_pause_ev = r_pause_s2 & ~r_pause_d;

  // Next-state, prescaler and strobe decisions; start outranks pause everywhere
  always_comb begin
    w_state  = r_state;
    w_presc  = r_presc;
    w_num    = r_num;
    w_load_n = 1'b1;
    w_dec_n  = 1'b1;
    w_last   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_ev) begin
          w_num    = load_val;
          w_load_n = 1'b0;
          w_state  = S_LOAD;
        end
      end
      S_LOAD: begin
        w_presc = '0;
        w_state = (r_num == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (w_start_ev) begin
          w_num    = load_val;
          w_load_n = 1'b0;
          w_state  = S_LOAD;
        end else if (w_pause_ev) begin
          // Prescaler holds its value so the resume continues the interval
          w_last  = r_last;
          w_state = S_PAUSE;
        end else if (r_last) begin
          w_state = S_DONE;
        end else if (r_presc == TC) begin
          w_presc = '0;
          if (cnt_val == '0) begin
            w_state = S_DONE;
          end else begin
            w_dec_n = 1'b0;
            w_last  = (cnt_val == WIDTH'(1));
          end
        end else begin
          w_presc = r_presc + PW'(1);
        end
      end
      S_PAUSE: begin
        w_last = r_last;
        if (w_start_ev) begin
          w_num    = load_val;
          w_load_n = 1'b0;
          w_last   = 1'b0;
          w_state  = S_LOAD;
        end else if (w_pause_ev) begin
          w_state = S_RUN;
        end
      end
      S_DONE: begin
        if (w_start_ev) begin
          w_num    = load_val;
          w_load_n = 1'b0;
          w_state  = S_LOAD;
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  // Register state, prescaler, load value and both strobes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_presc  <= '0;
      r_num    <= '0;
      r_load_n <= 1'b1;
      r_dec_n  <= 1'b1;
      r_last   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_presc  <= w_presc;
      r_num    <= w_num;
      r_load_n <= w_load_n;
      r_dec_n  <= w_dec_n;
      r_last   <= w_last;
    end
  end

  assign cnt_num    = r_num;
  assign cnt_load_n = r_load_n;
  assign cnt_dec_n  = r_dec_n;
  assign running    = (r_state == S_RUN);
  assign done       = (r_state == S_DONE);
  assign state      = r_state;

endmodule

// File: tb/tb_control_contador_regresivo.sv
// Bench for control_contador_regresivo with TICK_DIV=4, WIDTH=6.
// A behavioural countdown counter closes the loop on cnt_val; expected strobes
// (kind, value, cycles since the previous strobe) are queued by the stimulus
// and consumed by a monitor that watches cnt_load_n / cnt_dec_n.
module tb_control_contador_regresivo;

  logic       clk;
  logic       reset;
  logic       start;
  logic       pause;
  logic [5:0] load_val;
  logic [5:0] cnt_val;
  logic [5:0] cnt_num;
  logic       cnt_load_n;
  logic       cnt_dec_n;
  logic       running;
  logic       done;
  logic [2:0] state;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    bit is_dec;
    int val;
    int gap;
  } exp_t;
  exp_t exp_q[$];
  int   gap_cnt = 0;

  control_contador_regresivo #(.WIDTH(6), .TICK_DIV(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .pause      (pause),
    .load_val   (load_val),
    .cnt_val    (cnt_val),
    .cnt_num    (cnt_num),
    .cnt_load_n (cnt_load_n),
    .cnt_dec_n  (cnt_dec_n),
    .running    (running),
    .done       (done),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model of the countdown counter driven by the strobes
  initial cnt_val = 6'd0;
  always @(posedge clk) begin
    if (!cnt_load_n)     cnt_val <= cnt_num;
    else if (!cnt_dec_n) cnt_val <= cnt_val - 6'd1;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic push(input bit is_dec, input int val, input int gap);
    exp_t e;
    e.is_dec = is_dec;
    e.val    = val;
    e.gap    = gap;
    exp_q.push_back(e);
  endtask

  // Monitor: every strobe cycle pops one expectation and compares it
  always @(negedge clk) begin
    exp_t e;
    gap_cnt++;
    if (!cnt_load_n || !cnt_dec_n) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("strobe_kind", cnt_load_n ? 1 : 0, e.is_dec ? 1 : 0);
        check("strobe_val", cnt_load_n ? int'(cnt_val) : int'(cnt_num), e.val);
        if (e.gap >= 0) check("strobe_gap", gap_cnt, e.gap);
      end
      gap_cnt = 0;
    end
  end

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    pause    = 1'b0;
    load_val = 6'd0;

    // Reset state
    #2 reset = 1'b0;
    #1;
    check("rst_state", state, 0);
    check("rst_load_n", cnt_load_n, 1);
    check("rst_dec_n", cnt_dec_n, 1);
    check("rst_num", cnt_num, 0);
    check("rst_done", done, 0);
    check("rst_running", running, 0);
    tick(2);
    reset = 1'b1;
    tick(2);

    // Countdown from 3
    load_val = 6'd3;
    push(0, 3, -1); push(1, 3, 5); push(1, 2, 4); push(1, 1, 4);
    press_start();
    tick(17);
    check("a_done", done, 1);
    check("a_state", state, 4);
    check("a_running", running, 0);
    tick(20);
    check("a_queue_empty", exp_q.size(), 0);

    // Zero load value goes straight to DONE
    load_val = 6'd0;
    push(0, 0, -1);
    press_start();
    tick(3);
    check("b_state", state, 4);
    check("b_done", done, 1);
    tick(12);
    check("b_queue_empty", exp_q.size(), 0);

    // Count from 8 with a pause after two decrements
    load_val = 6'd8;
    push(0, 8, -1); push(1, 8, 5); push(1, 7, 4);
    press_start();
    tick(11);
    pause = 1'b1;
    tick(1);
    pause = 1'b0;
    tick(2);
    check("c_pause_state", state, 3);
    check("c_pause_running", running, 0);
    tick(20);
    check("c_pause_held", state, 3);
    push(1, 6, 28); push(1, 5, 4); push(1, 4, 4);
    push(1, 3, 4); push(1, 2, 4); push(1, 1, 4);
    pause = 1'b1;
    tick(1);
    pause = 1'b0;
    tick(26);
    check("c_done", done, 1);
    check("c_queue_empty", exp_q.size(), 0);

    // Restart while running with cnt_val=4
    load_val = 6'd6;
    push(0, 6, -1); push(1, 6, 5); push(1, 5, 4);
    press_start();
    tick(11);
    load_val = 6'd5;
    push(0, 5, 3); push(1, 5, 5); push(1, 4, 4);
    push(1, 3, 4); push(1, 2, 4); push(1, 1, 4);
    press_start();
    tick(3);
    check("d_num", cnt_num, 5);
    check("d_state", state, 2);
    tick(22);
    check("d_done", done, 1);
    check("d_queue_empty", exp_q.size(), 0);

    // Simultaneous start and pause in RUN: start wins
    load_val = 6'd4;
    push(0, 4, -1); push(0, 4, 5);
    press_start();
    tick(4);
    push(1, 4, 5); push(1, 3, 4); push(1, 2, 4); push(1, 1, 4);
    start = 1'b1;
    pause = 1'b1;
    tick(1);
    start = 1'b0;
    pause = 1'b0;
    tick(2);
    check("e_state_load", state, 1);
    tick(19);
    check("e_done", done, 1);
    check("e_queue_empty", exp_q.size(), 0);

    // Start held high in DONE gives one load strobe
    load_val = 6'd0;
    push(0, 0, -1);
    start = 1'b1;
    tick(10);
    start = 1'b0;
    tick(5);
    check("f_state", state, 4);
    check("f_queue_empty", exp_q.size(), 0);

    // Asynchronous reset in the middle of RUN
    load_val = 6'd5;
    push(0, 5, -1);
    press_start();
    tick(4);
    check("g_run_state", state, 2);
    check("g_run_running", running, 1);
    #2 reset = 1'b0;
    #1;
    check("g_rst_state", state, 0);
    check("g_rst_load_n", cnt_load_n, 1);
    check("g_rst_dec_n", cnt_dec_n, 1);
    check("g_rst_done", done, 0);
    check("g_rst_running", running, 0);
    check("g_rst_num", cnt_num, 0);
    tick(1);
    reset = 1'b1;
    tick(8);
    check("g_idle_state", state, 0);
    check("g_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
